// File: rtl/pacman_soc_gpio_pio.sv
// -----------------------------------------------------------------------------
// pacman_soc_gpio_pio
//
// Parametrised Avalon-MM GPIO slave with zero wait states. It provides:
//   - per-bit direction
//   - atomic output set/clear
//   - synchronised inputs
//   - edge capture with a maskable level interrupt
//
// Register map (word address):
//   0 DATA     W: data_out                 R: (data_out & dir) | (in_sync & ~dir)
//   1 DIR      R/W direction (1 = output)
//   2 IRQMASK  R/W interrupt mask
//   3 EDGECAP  R: captured edges           W: 1 clears the bit
//   4 OUTSET   W: data_out |= writedata    R: 0
//   5 OUTCLEAR W: data_out &= ~writedata   R: 0
//   6,7        R: 0, writes ignored
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address, chipselect,  Avalon-MM slave bus; write = chipselect & ~write_n
//   write_n, writedata,
//   readdata              combinational read, zero-extended above WIDTH
//   in_port               asynchronous pin inputs
//   out_port, oe_port     output data and output-enable per bit
//   irq                   |(edge_cap & irq_mask)
// -----------------------------------------------------------------------------
module pacman_soc_gpio_pio #(
  parameter int          WIDTH       = 14,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] RESET_DIR   = 32'h0,
  parameter int          EDGE_TYPE   = 0,   // 0 rising, 1 falling, 2 any
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_IRQMASK  = 3'd2;
  localparam logic [2:0] REG_EDGECAP  = 3'd3;
  localparam logic [2:0] REG_OUTSET   = 3'd4;
  localparam logic [2:0] REG_OUTCLEAR = 3'd5;

  // The capture path needs SYNC_STAGES+1 edges to flush reset zeros out of the
  // synchroniser and in_prev; only then is the edge detector trustworthy.
  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev;
  logic [2:0]       arm_cnt;
  logic             armed;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] edge_det;

  assign wr_en   = chipselect & ~write_n;
  assign wr_data = writedata[WIDTH-1:0];
  assign in_sync = sync_q[SYNC_STAGES-1];
  assign armed   = (arm_cnt == ARM_MAX);
  assign cap_clr = (wr_en && address == REG_EDGECAP) ? wr_data : '0;

  generate
    if (WIDTH < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  // Bus-writable registers.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE[WIDTH-1:0];
      dir      <= RESET_DIR[WIDTH-1:0];
      irq_mask <= '0;
    end else if (wr_en) begin
      case (address)
        REG_DATA:     data_out <= wr_data;
        REG_DIR:      dir      <= wr_data;
        REG_IRQMASK:  irq_mask <= wr_data;
        REG_OUTSET:   data_out <= data_out | wr_data;
        REG_OUTCLEAR: data_out <= data_out & ~wr_data;
        default:      ;
      endcase
    end
  end

  // Input synchroniser, previous-sample register and arm counter.
  // NOTE: the synchroniser array is reset explicitly element by element; a
  // register array without a reset would leave power-up garbage that the edge
  // detector could interpret as a pin transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev <= in_sync;
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
    end
  end

  // Edge detector, selected by EDGE_TYPE.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = in_sync & ~in_prev;
      1:       edge_det = ~in_sync & in_prev;
      default: edge_det = in_sync ^ in_prev;
    endcase
  end

  // Capture: a new detect wins over a simultaneous clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | (armed ? edge_det : '0);
    end
  end

  // Read mux: pure function of registers and address, no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA:    readdata = 32'((data_out & dir) | (in_sync & ~dir));
      REG_DIR:     readdata = 32'(dir);
      REG_IRQMASK: readdata = 32'(irq_mask);
      REG_EDGECAP: readdata = 32'(edge_cap);
      default:     readdata = '0;
    endcase
  end

  assign out_port = data_out;
  assign oe_port  = dir;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: doc/pacman_soc_gpio_pio.md
Name: pacman_soc_gpio_pio

Overview:
Parametrised Avalon-MM general-purpose I/O block for pacman_soc. It is the successor to the fixed 14-bit output-only LED PIO and adds the following:
- configurable width
- per-bit direction
- atomic bit set/clear writes
- synchronised input sampling
- edge capture with a maskable level interrupt

It sits on the system interconnect as a zero-wait-state slave. Typical users are LEDs, switches and keys.

Parameters:
WIDTH, 14, number of GPIO bits (1..32).
RESET_VALUE, 0, reset value of the output data register (low WIDTH bits used).
RESET_DIR, 0, reset value of the direction register (1 = output).
EDGE_TYPE, 0, edge that sets capture bits: 0 rising, 1 falling, 2 any.
SYNC_STAGES, 2, input synchroniser depth (2..3).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
address  input  3  register word address.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe, qualified by chipselect.
writedata  input  32  write data; bits above WIDTH ignored.
readdata  output  32  read data, zero-extended above WIDTH.
in_port  input  WIDTH  asynchronous pin inputs.
out_port  output  WIDTH  output data register.
oe_port  output  WIDTH  direction register (1 = drive pin from out_port).
irq  output  1  level interrupt.

Behaviour:
- Reset (asynchronous, reset_n low):
  - data_out = RESET_VALUE, dir = RESET_DIR.
  - irq_mask = 0, edge_cap = 0.
  - Synchroniser and previous-sample registers = 0.
  - Arm counter = 0.
  - Resulting outputs: out_port = RESET_VALUE, oe_port = RESET_DIR, irq = 0.
- Write = chipselect & ~write_n, taking effect at the next clk edge.
- Register map:
  - 0 DATA: write sets data_out. Read returns (data_out & dir) | (in_sync & ~dir).
  - 1 DIRECTION: read/write dir.
  - 2 IRQMASK: read/write irq_mask.
  - 3 EDGECAP: read edge_cap. Writing 1 clears that bit; writing 0 leaves it unchanged.
  - 4 OUTSET: write-only, data_out |= writedata. Reads return 0.
  - 5 OUTCLEAR: write-only, data_out &= ~writedata. Reads return 0.
  - 6, 7: reads return 0, writes are ignored.
- Reads are combinational from registers. readdata is valid in the same cycle as address, with zero wait states. Reads have no side effects.
- Synchroniser: in_port passes through SYNC_STAGES flops to give in_sync. in_prev is in_sync delayed by one flop.
- Edge detect is combinational:
  - rising = in_sync & ~in_prev
  - falling = ~in_sync & in_prev
  - any = rising | falling
  - Applies to all bits regardless of dir.
- Capture: edge_cap bit is set on the clk edge after the detect is asserted.
  - A pin change meeting setup before edge 1 is visible in in_sync after edge SYNC_STAGES.
  - It is visible in edge_cap after edge SYNC_STAGES+1.
- Simultaneous EDGECAP clear and new detect on the same bit: set wins, so the bit stays 1.
- Arm counter:
  - Counts 0..SYNC_STAGES+1 after reset release, then saturates.
  - edge_cap cannot set until the count reaches SYNC_STAGES+1.
  - This prevents spurious edges from pins held at 1 through reset.
- irq = |(edge_cap & irq_mask), combinational from registers.
  - Setting a mask bit while its capture bit is already 1 asserts irq the cycle after the write.
- Asserting reset_n low mid-operation clears every register immediately. The arm sequence restarts on release.

Test Plan:
- Reset with RESET_VALUE=14'h0A5, RESET_DIR=14'h3FFF, pins all 1 -> out_port=0x0A5, oe_port=0x3FFF, irq=0. edge_cap stays 0 for 10 cycles after release.
- Write DATA=0x1234, DIRECTION=0x00FF, drive in_port=0x3F00, wait SYNC_STAGES+1 cycles -> read DATA returns 0x3F34. Read address 6 returns 0.
- data_out=0x00F0; write OUTSET=0x0003, then OUTCLEAR=0x0030 -> out_port=0x00F3, then 0x00C3. Bits above WIDTH are ignored.
- EDGE_TYPE=0, SYNC_STAGES=2, IRQMASK=0x0001; raise in_port[0] -> edge_cap[0]=1 exactly after the 3rd edge and irq=1. Lower in_port[0] -> no change. Write EDGECAP=1 -> irq=0 next cycle.
- Write EDGECAP=0x1 on the same cycle as a new rising detect on bit 0 -> edge_cap[0] remains 1. EDGE_TYPE=2 captures both edges.
- Assert reset_n mid-capture with irq=1 -> irq, out_port and edge_cap go to reset values immediately, with no clk edge required.
